// File: rtl/sdram_pack.sv
// Packs 12-bit RGB pixels into 32-bit SDRAM words (two 16-bit halves) and buffers them
// in a first-word-fall-through FIFO with overflow, per-frame pixel and frame-start counters.
module sdram_pack #(
   parameter int DEPTH = 8
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic [11:0] iRed,
   input  logic [11:0] iGreen,
   input  logic [11:0] iBlue,
   input  logic        iDVAL,
   input  logic        iFVAL,
   input  logic        iREADY,
   output logic [31:0] oDATA,
   output logic        oVALID,
   output logic        oOVF,
   output logic [19:0] oPIX_CNT,
   output logic [7:0]  oFRAME_CNT
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

   logic [31:0]   w_pack;
   logic [31:0]   r_stg_data;
   logic          r_stg_vld;
   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_cnt;
   logic          r_fval_q;
   logic          r_armed;
   logic          r_ovf;
   logic [19:0]   r_pix;
   logic [7:0]    r_frame;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_start;
   logic          w_unused;

   assign w_pack   = {1'b0, iGreen[11:7], iBlue[11:2], 1'b0, iGreen[6:2], iRed[11:2]};
   assign w_unused = ^{iRed[1:0], iGreen[1:0], iBlue[1:0]};

   assign w_full  = (r_cnt == L_FULL);
   assign w_pop   = (r_cnt != '0) & iREADY;
   // a full FIFO still accepts a word when the head leaves on the same edge
   assign w_push  = r_stg_vld & (~w_full | w_pop);
   // r_armed blocks a false start when iFVAL is already high out of reset
   assign w_start = iFVAL & ~r_fval_q & r_armed;

   always_ff @(posedge iCLK) begin
      if (iDVAL)
         r_stg_data <= w_pack;
   end

   always_ff @(posedge iCLK) begin
      if (w_push)
         r_mem[r_wr_ptr] <= r_stg_data;
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_stg_vld <= 1'b0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
      end else begin
         r_stg_vld <= iDVAL;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
         if (r_stg_vld & ~w_push)
            r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_fval_q <= 1'b0;
         r_armed  <= 1'b0;
         r_pix    <= '0;
         r_frame  <= '0;
      end else begin
         r_fval_q <= iFVAL;
         if (!iFVAL)
            r_armed <= 1'b1;
         if (w_start) begin
            r_frame <= r_frame + 8'd1;
            r_pix   <= {19'd0, w_push};
         end else if (w_push && (r_pix != '1)) begin
            r_pix <= r_pix + 20'd1;
         end
      end
   end

   assign oVALID     = (r_cnt != '0);
   assign oDATA      = r_mem[r_rd_ptr];
   assign oOVF       = r_ovf;
   assign oPIX_CNT   = r_pix;
   assign oFRAME_CNT = r_frame;

endmodule

// File: tb/tb_sdram_pack.sv
// Self-checking bench for sdram_pack: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized traffic phase.
module tb_sdram_pack;
   localparam int DEPTH = 8;

   logic        iCLK = 1'b0;
   logic        iRST = 1'b1;
   logic [11:0] iRed = '0, iGreen = '0, iBlue = '0;
   logic        iDVAL = 1'b0, iFVAL = 1'b0, iREADY = 1'b0;
   logic [31:0] oDATA;
   logic        oVALID, oOVF;
   logic [19:0] oPIX_CNT;
   logic [7:0]  oFRAME_CNT;

   int n_total = 0;
   int n_bad   = 0;

   sdram_pack #(.DEPTH(DEPTH)) dut (
      .iCLK(iCLK), .iRST(iRST),
      .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
      .iDVAL(iDVAL), .iFVAL(iFVAL), .iREADY(iREADY),
      .oDATA(oDATA), .oVALID(oVALID), .oOVF(oOVF),
      .oPIX_CNT(oPIX_CNT), .oFRAME_CNT(oFRAME_CNT)
   );

   always #5 iCLK = ~iCLK;

   function automatic logic [31:0] pack(input logic [11:0] r, input logic [11:0] g,
                                        input logic [11:0] b);
      return {1'b0, g[11:7], b[11:2], 1'b0, g[6:2], r[11:2]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: words seen last cycle enter a bounded queue
   logic [31:0] m_q[$];
   bit          m_sv, m_fq, m_armed, m_ovf;
   logic [31:0] m_sw;
   int          m_pix, m_frame;

   always @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         m_q.delete();
         m_sv = 0; m_fq = 0; m_armed = 0; m_ovf = 0; m_pix = 0; m_frame = 0;
      end else begin
         bit pop, acc, st;
         pop = (m_q.size() != 0) && iREADY;
         acc = m_sv && ((m_q.size() < DEPTH) || pop);
         st  = iFVAL && !m_fq && m_armed;
         if (m_sv && !acc) m_ovf = 1;
         if (pop) void'(m_q.pop_front());
         if (acc) m_q.push_back(m_sw);
         if (st) begin
            m_frame = (m_frame + 1) % 256;
            m_pix   = acc ? 1 : 0;
         end else if (acc && m_pix < (1 << 20) - 1) begin
            m_pix++;
         end
         m_sv = iDVAL;
         m_sw = pack(iRed, iGreen, iBlue);
         m_fq = iFVAL;
         if (!iFVAL) m_armed = 1;
      end
   end

   always @(negedge iCLK) begin
      if (!iRST) begin
         chk("m_valid", {31'd0, oVALID}, {31'd0, m_q.size() != 0});
         if (m_q.size() != 0) chk("m_data", oDATA, m_q[0]);
         chk("m_ovf", {31'd0, oOVF}, {31'd0, m_ovf});
         chk("m_pix", {12'd0, oPIX_CNT}, m_pix);
         chk("m_frame", {24'd0, oFRAME_CNT}, m_frame);
      end
   end

   task automatic step();
      @(negedge iCLK);
   endtask

   task automatic do_reset();
      iRST = 1'b1;
      step();
      iRST = 1'b0;
   endtask

   task automatic rnd_pix();
      iRed   = 12'($urandom);
      iGreen = 12'($urandom);
      iBlue  = 12'($urandom);
   endtask

   initial begin
      int n;
      step(); step();
      iRST = 1'b0;
      step();
      chk("rst_valid", {31'd0, oVALID}, 0);
      chk("rst_ovf", {31'd0, oOVF}, 0);
      chk("rst_pix", {12'd0, oPIX_CNT}, 0);
      chk("rst_frame", {24'd0, oFRAME_CNT}, 0);

      // single pixel, two-edge latency
      iREADY = 1'b1;
      iRed = 12'hFFF; iGreen = 12'hABC; iBlue = 12'h004; iDVAL = 1'b1;
      step();
      iDVAL = 1'b0;
      chk("single_lat1", {31'd0, oVALID}, 0);
      step();
      chk("single_valid", {31'd0, oVALID}, 1);
      chk("single_data", oDATA, 32'h5401_3FFF);
      step();
      chk("single_pop", {31'd0, oVALID}, 0);

      // full FIFO with simultaneous pop: nothing dropped
      iREADY = 1'b0;
      for (int i = 0; i <= DEPTH; i++) begin
         rnd_pix(); iDVAL = 1'b1; step();
      end
      iREADY = 1'b1;
      for (int i = 0; i < 20; i++) begin
         rnd_pix(); step();
      end
      iDVAL = 1'b0;
      for (int i = 0; i < 2 * DEPTH; i++) step();
      chk("fullpop_ovf", {31'd0, oOVF}, 0);
      chk("fullpop_pix", {12'd0, oPIX_CNT}, 1 + DEPTH + 1 + 20);

      // backpressure overflow then drain in order
      do_reset();
      iREADY = 1'b0;
      for (int i = 0; i < DEPTH + 3; i++) begin
         iRed = 12'(i * 4 + 4); iGreen = 12'(i * 132); iBlue = 12'(12'h800 + i * 4);
         iDVAL = 1'b1; step();
      end
      iDVAL = 1'b0;
      step(); step();
      chk("bp_ovf", {31'd0, oOVF}, 1);
      chk("bp_pix", {12'd0, oPIX_CNT}, DEPTH);
      iREADY = 1'b1;
      n = 0;
      for (int k = 0; k < 3 * DEPTH; k++) begin
         if (oVALID) begin
            if (n < DEPTH)
               chk("bp_drain", oDATA, pack(12'(n * 4 + 4), 12'(n * 132), 12'(12'h800 + n * 4)));
            n++;
         end
         step();
      end
      chk("bp_drain_cnt", n, DEPTH);

      // three frames of 100 pixels, first pixel coincides with frame start
      do_reset();
      iREADY = 1'b1;
      for (int f = 0; f < 3; f++) begin
         for (int c = 0; c < 102; c++) begin
            rnd_pix();
            iDVAL = (c < 100);
            iFVAL = (c >= 1);
            step();
            if (c == 1) chk("frm_start_pix", {12'd0, oPIX_CNT}, 1);
         end
         iFVAL = 1'b0; iDVAL = 1'b0;
         step(); step(); step();
      end
      chk("frm_count", {24'd0, oFRAME_CNT}, 3);
      chk("frm_pix", {12'd0, oPIX_CNT}, 100);

      // async reset with 5 buffered words; iFVAL high across release
      iREADY = 1'b0;
      iFVAL = 1'b1; step();
      iFVAL = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rnd_pix(); iDVAL = 1'b1; step();
      end
      iDVAL = 1'b0;
      step(); step();
      chk("pre_rst_valid", {31'd0, oVALID}, 1);
      chk("pre_rst_frame", {24'd0, oFRAME_CNT}, 4);
      iFVAL = 1'b1;
      @(posedge iCLK);
      #2 iRST = 1'b1;
      #1;
      chk("arst_valid", {31'd0, oVALID}, 0);
      chk("arst_ovf", {31'd0, oOVF}, 0);
      chk("arst_pix", {12'd0, oPIX_CNT}, 0);
      chk("arst_frame", {24'd0, oFRAME_CNT}, 0);
      step(); step();
      iRST = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("fval_high_rel", {24'd0, oFRAME_CNT}, 0);
      chk("rst_flushed", {31'd0, oVALID}, 0);
      iFVAL = 1'b0; step();
      iFVAL = 1'b1; step();
      chk("fval_rearm", {24'd0, oFRAME_CNT}, 1);

      // frame counter wrap after 256 starts
      for (int i = 0; i < 255; i++) begin
         iFVAL = 1'b0; step();
         iFVAL = 1'b1; step();
      end
      chk("frame_wrap", {24'd0, oFRAME_CNT}, 0);
      iFVAL = 1'b0;

      // pointer wrap with streaming output
      iREADY = 1'b1;
      for (int i = 0; i < 3 * DEPTH; i++) begin
         rnd_pix(); iDVAL = 1'b1; step();
      end
      iDVAL = 1'b0;
      for (int i = 0; i < 4; i++) step();

      // randomized traffic
      do_reset();
      for (int i = 0; i < 800; i++) begin
         rnd_pix();
         iDVAL  = ($urandom_range(0, 99) < 60);
         iREADY = ($urandom_range(0, 99) < 70);
         if ($urandom_range(0, 99) < 4) iFVAL = ~iFVAL;
         step();
      end
      iDVAL = 1'b0; iREADY = 1'b1;
      for (int i = 0; i < 2 * DEPTH; i++) step();
      chk("rand_drained", {31'd0, oVALID}, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
